// File: rtl/spi_master_if.sv
// SPI master bus bundle.
// Carries the parallel request/response handshake (start, d, q, busy, done) together with
// the serial pins (sck, cs_n, mosi, miso).
//   master modport: used by spi_master; it drives q/busy/done/sck/cs_n/mosi and reads the rest.
//   slave  modport: used by whatever sits on the far side; it drives start/d/miso.
interface spi_master_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  start;
    logic [DATA_WIDTH-1:0] d;
    logic [DATA_WIDTH-1:0] q;
    logic                  busy;
    logic                  done;
    logic                  sck;
    logic                  cs_n;
    logic                  mosi;
    logic                  miso;

    modport master (
        input  start, d, miso,
        output q, busy, done, sck, cs_n, mosi
    );

    modport slave (
        output start, d, miso,
        input  q, busy, done, sck, cs_n, mosi
    );
endinterface

// File: rtl/spi_master.sv
// SPI mode-0 master. Sends one DATA_WIDTH-bit word MSB first and receives one word at the
// same time.
// Ports:
//   clk   - system clock; all logic runs on its rising edge
//   reset - synchronous, active-high
//   bus   - spi_master_if.master: start/d request, q/done result, busy, sck/cs_n/mosi/miso
// A frame runs SETUP (cs_n low, first bit on mosi), SHIFT (2*DATA_WIDTH sck half-periods,
// starting high), HOLD (cs_n still low) and GAP (cs_n high). Each phase is CLK_DIV clk
// cycles long. done pulses on the first GAP cycle.
module spi_master #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CLK_DIV    = 4
) (
    input  logic         clk,
    input  logic         reset,
    spi_master_if.master bus
);
    localparam int unsigned DivW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned HalfW = (DATA_WIDTH > 1) ? $clog2(2 * DATA_WIDTH) : 1;

    localparam logic [DivW-1:0]  DivLast   = DivW'(CLK_DIV - 1);
    localparam logic [DivW-1:0]  DivOne    = DivW'(1);
    localparam logic [HalfW-1:0] HalfLast  = HalfW'(2 * DATA_WIDTH - 1);
    localparam logic [HalfW-1:0] HalfOne   = HalfW'(1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StGap
    } state_e;

    state_e                state_q, state_d;
    logic [DivW-1:0]       div_q, div_d;
    logic [HalfW-1:0]      half_q, half_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic [DATA_WIDTH-1:0] q_q, q_d;
    logic                  sck_q, sck_d;
    logic                  done_q, done_d;
    logic                  miso_meta_q, miso_sync_q;
    logic                  div_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            div_q       <= '0;
            half_q      <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            q_q         <= '0;
            sck_q       <= 1'b0;
            done_q      <= 1'b0;
            miso_meta_q <= 1'b0;
            miso_sync_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            half_q      <= half_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            q_q         <= q_d;
            sck_q       <= sck_d;
            done_q      <= done_d;
            miso_meta_q <= bus.miso;
            miso_sync_q <= miso_meta_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        half_d   = half_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        q_d      = q_q;
        sck_d    = sck_q;
        done_d   = 1'b0;
        div_last = (div_q == DivLast);

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StSetup;
                    tx_d    = bus.d;
                    rx_d    = '0;
                    div_d   = '0;
                    half_d  = '0;
                    sck_d   = 1'b0;
                end
            end

            StSetup: begin
                if (div_last) begin
                    state_d = StShift;
                    div_d   = '0;
                    sck_d   = 1'b1;
                end else begin
                    div_d = div_q + DivOne;
                end
            end

            StShift: begin
                // The two-flop synchroniser delays miso by two cycles, so sampling on the
                // second cycle of the high phase captures miso as it was at the sck rising
                // edge. CLK_DIV >= 2 keeps this inside the high phase.
                if (sck_q && (div_q == DivOne)) begin
                    rx_d = {rx_q[DATA_WIDTH-2:0], miso_sync_q};
                end
                if (div_last) begin
                    div_d = '0;
                    if (half_q == HalfLast) begin
                        // Final falling edge: mosi keeps the last bit through HOLD.
                        state_d = StHold;
                        sck_d   = 1'b0;
                    end else begin
                        half_d = half_q + HalfOne;
                        sck_d  = ~sck_q;
                        if (sck_q) begin
                            tx_d = {tx_q[DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                end else begin
                    div_d = div_q + DivOne;
                end
            end

            StHold: begin
                if (div_last) begin
                    state_d = StGap;
                    div_d   = '0;
                    done_d  = 1'b1;
                    q_d     = rx_q;
                end else begin
                    div_d = div_q + DivOne;
                end
            end

            StGap: begin
                if (div_last) begin
                    state_d = StIdle;
                    div_d   = '0;
                end else begin
                    div_d = div_q + DivOne;
                end
            end

            default: begin
                state_d = StIdle;
                div_d   = '0;
                sck_d   = 1'b0;
            end
        endcase
    end

    assign bus.busy = (state_q != StIdle);
    assign bus.cs_n = (state_q == StIdle) || (state_q == StGap);
    assign bus.sck  = sck_q;
    assign bus.mosi = ((state_q == StSetup) || (state_q == StShift) || (state_q == StHold))
                      ? tx_q[DATA_WIDTH-1] : 1'b0;
    assign bus.done = done_q;
    assign bus.q    = q_q;
endmodule

// File: tb/tb_spi_master.sv
// Testbench for spi_master: a 32-bit/CLK_DIV=4 instance (loopback or slave model on miso)
// and an 8-bit/CLK_DIV=2 instance in loopback. Expected values come from the frame rules:
// a loopback frame returns the sent word, a slave sees the sent word and q is the slave word,
// and done lands (2*DATA_WIDTH+2)*CLK_DIV+1 cycles after acceptance.
module tb_spi_master;
    localparam int DW   = 32;
    localparam int CD   = 4;
    localparam int LAT  = (2 * DW + 2) * CD + 1;
    localparam int IDLE = LAT + CD;
    localparam int DW2  = 8;
    localparam int CD2  = 2;
    localparam int LAT2 = (2 * DW2 + 2) * CD2 + 1;

    logic clk = 1'b0;
    logic reset;
    logic loop_mode;
    logic slave_miso;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    spi_master_if #(.DATA_WIDTH(DW))  bus ();
    spi_master_if #(.DATA_WIDTH(DW2)) bus2 ();

    assign bus.miso  = loop_mode ? bus.mosi : slave_miso;
    assign bus2.miso = bus2.mosi;

    spi_master #(.DATA_WIDTH(DW), .CLK_DIV(CD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    spi_master #(.DATA_WIDTH(DW2), .CLK_DIV(CD2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    // Runs one frame on the 32-bit instance starting at the current negedge (cycle 0) and
    // returns what was observed; stops at the first idle cycle or after 600 cycles.
    task automatic run_frame(input logic [31:0] word, input bit loop, input logic [31:0] sword,
                             input bit inject, output int done_cyc, output int ndone,
                             output int rises, output int cs_bad, output logic [31:0] cap,
                             output logic [31:0] q_at_done, output int busy_drop);
        int   c;
        int   sbit;
        logic prev_sck;
        done_cyc  = -1;
        ndone     = 0;
        rises     = 0;
        cs_bad    = 0;
        cap       = '0;
        q_at_done = '0;
        busy_drop = -1;
        sbit      = 31;
        prev_sck  = 1'b0;
        loop_mode = loop;
        slave_miso = sword[31];
        bus.d     = word;
        bus.start = 1'b1;
        @(negedge clk);
        c = 1;
        bus.start = 1'b0;
        bus.d     = ~word;
        while (c < 600) begin
            if (bus.sck && !prev_sck) begin
                rises++;
                if (bus.cs_n !== 1'b0) cs_bad++;
                cap = {cap[30:0], bus.mosi};
            end
            if (!bus.sck && prev_sck && sbit > 0) begin
                sbit--;
                slave_miso = sword[sbit];
            end
            prev_sck = bus.sck;
            if (bus.done === 1'b1) begin
                ndone++;
                if (done_cyc < 0) begin
                    done_cyc  = c;
                    q_at_done = bus.q;
                end
            end
            if (bus.busy !== 1'b1) begin
                busy_drop = c;
                break;
            end
            if (inject && (c == 10 || c == LAT)) begin
                bus.start = 1'b1;
                bus.d     = $urandom();
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            c++;
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        n_tests++;
        if (bus.cs_n !== 1'b1) begin n_fail++; $display("FAIL reset_cs_n: got %b expected 1", bus.cs_n); end
        n_tests++;
        if (bus.sck !== 1'b0) begin n_fail++; $display("FAIL reset_sck: got %b expected 0", bus.sck); end
        n_tests++;
        if (bus.mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b expected 0", bus.mosi); end
        n_tests++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_tests++;
        if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        n_tests++;
        if (bus.q !== 32'h0) begin n_fail++; $display("FAIL reset_q: got %h expected 0", bus.q); end
        n_tests++;
        if (bus2.cs_n !== 1'b1 || bus2.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_small: got cs_n=%b busy=%b expected cs_n=1 busy=0", bus2.cs_n, bus2.busy);
        end
    endtask

    task automatic test_loopback();
        int dc, nd, r, cb, bd;
        logic [31:0] cap, qd;
        logic [31:0] w;
        w = 32'hA5C3_0F81;
        run_frame(w, 1'b1, 32'h0, 1'b0, dc, nd, r, cb, cap, qd, bd);
        n_tests++;
        if (dc !== LAT) begin n_fail++; $display("FAIL loop_done_cycle: got %0d expected %0d", dc, LAT); end
        n_tests++;
        if (nd !== 1) begin n_fail++; $display("FAIL loop_done_count: got %0d expected 1", nd); end
        n_tests++;
        if (qd !== w) begin n_fail++; $display("FAIL loop_q: got %h expected %h", qd, w); end
        n_tests++;
        if (r !== DW) begin n_fail++; $display("FAIL loop_rises: got %0d expected %0d", r, DW); end
        n_tests++;
        if (cb !== 0) begin n_fail++; $display("FAIL loop_cs_at_rise: got %0d bad expected 0", cb); end
        n_tests++;
        if (cap !== w) begin n_fail++; $display("FAIL loop_mosi_word: got %h expected %h", cap, w); end
        n_tests++;
        if (bd !== IDLE) begin n_fail++; $display("FAIL loop_busy_drop: got %0d expected %0d", bd, IDLE); end
        bus.d = $urandom();
        repeat (5) @(negedge clk);
        n_tests++;
        if (bus.q !== w) begin n_fail++; $display("FAIL loop_q_hold: got %h expected %h", bus.q, w); end
    endtask

    task automatic test_slave();
        int dc, nd, r, cb, bd;
        logic [31:0] cap, qd;
        run_frame(32'h1234_5678, 1'b0, 32'hDEAD_BEEF, 1'b0, dc, nd, r, cb, cap, qd, bd);
        n_tests++;
        if (cap !== 32'h1234_5678) begin n_fail++; $display("FAIL slave_capture: got %h expected 12345678", cap); end
        n_tests++;
        if (qd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL slave_q: got %h expected deadbeef", qd); end
        n_tests++;
        if (dc !== LAT) begin n_fail++; $display("FAIL slave_done_cycle: got %0d expected %0d", dc, LAT); end
    endtask

    task automatic test_random();
        int dc, nd, r, cb, bd;
        logic [31:0] cap, qd, w, sw, exp_q;
        bit lp;
        for (int i = 0; i < 6; i++) begin
            w  = $urandom();
            sw = $urandom();
            lp = (i % 2 == 0);
            exp_q = lp ? w : sw;
            run_frame(w, lp, sw, 1'b0, dc, nd, r, cb, cap, qd, bd);
            n_tests++;
            if (qd !== exp_q || cap !== w || dc !== LAT) begin
                n_fail++;
                $display("FAIL random_frame%0d: got q=%h sent=%h done=%0d expected q=%h sent=%h done=%0d",
                         i, qd, cap, dc, exp_q, w, LAT);
            end
        end
    endtask

    task automatic test_ignored_start();
        int dc, nd, r, cb, bd, busy_seen;
        logic [31:0] cap, qd, w;
        w = $urandom();
        run_frame(w, 1'b1, 32'h0, 1'b1, dc, nd, r, cb, cap, qd, bd);
        n_tests++;
        if (dc !== LAT || nd !== 1) begin
            n_fail++;
            $display("FAIL ignore_done: got cycle %0d count %0d expected cycle %0d count 1", dc, nd, LAT);
        end
        n_tests++;
        if (qd !== w) begin n_fail++; $display("FAIL ignore_q: got %h expected %h", qd, w); end
        n_tests++;
        if (bd !== IDLE) begin n_fail++; $display("FAIL ignore_busy_drop: got %0d expected %0d", bd, IDLE); end
        busy_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.busy !== 1'b0) busy_seen++;
        end
        n_tests++;
        if (busy_seen !== 0) begin n_fail++; $display("FAIL ignore_not_queued: got %0d busy cycles expected 0", busy_seen); end
    endtask

    task automatic test_back_to_back();
        int dc, nd, r, cb, bd;
        logic [31:0] cap, qd, w1, w2;
        w1 = $urandom();
        w2 = $urandom();
        run_frame(w1, 1'b1, 32'h0, 1'b0, dc, nd, r, cb, cap, qd, bd);
        // Starts on the very first idle cycle after the previous GAP.
        run_frame(w2, 1'b1, 32'h0, 1'b0, dc, nd, r, cb, cap, qd, bd);
        n_tests++;
        if (dc !== LAT || qd !== w2) begin
            n_fail++;
            $display("FAIL b2b_second: got done=%0d q=%h expected done=%0d q=%h", dc, qd, LAT, w2);
        end
    endtask

    task automatic test_d_change();
        int dc, nd, r, cb, bd;
        logic [31:0] cap, qd, w;
        w = 32'h0F0F_F0F0;
        run_frame(w, 1'b1, 32'h0, 1'b0, dc, nd, r, cb, cap, qd, bd);
        n_tests++;
        if (cap !== w || qd !== w) begin
            n_fail++;
            $display("FAIL d_change: got sent=%h q=%h expected %h", cap, qd, w);
        end
    endtask

    task automatic test_reset_midframe();
        int seen;
        loop_mode = 1'b1;
        bus.d     = $urandom();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (99) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.cs_n !== 1'b1 || bus.sck !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_pins: got cs_n=%b sck=%b busy=%b done=%b expected 1 0 0 0",
                     bus.cs_n, bus.sck, bus.busy, bus.done);
        end
        n_tests++;
        if (bus.q !== 32'h0) begin n_fail++; $display("FAIL midreset_q: got %h expected 0", bus.q); end
        reset = 1'b0;
        seen  = 0;
        repeat (300) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen++;
        end
        n_tests++;
        if (seen !== 0) begin n_fail++; $display("FAIL midreset_quiet: got %0d active cycles expected 0", seen); end
    endtask

    task automatic test_reset_start();
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.d     = $urandom();
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0 || bus.cs_n !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_start: got busy=%b cs_n=%b expected busy=0 cs_n=1", bus.busy, bus.cs_n);
        end
        reset     = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_start_after: got busy=%b expected 0", bus.busy); end
    endtask

    task automatic test_small();
        logic [7:0] words [4];
        words[0] = 8'h81;
        for (int i = 1; i < 4; i++) words[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 4; i++) begin
            int c, dc, r1, r2, nr;
            logic [7:0] qd;
            logic prev;
            dc = -1; r1 = -1; r2 = -1; nr = 0; prev = 1'b0; qd = '0;
            bus2.d     = words[i];
            bus2.start = 1'b1;
            @(negedge clk);
            c = 1;
            bus2.start = 1'b0;
            bus2.d     = ~words[i];
            while (c < 100) begin
                if (bus2.sck && !prev) begin
                    nr++;
                    if (r1 < 0) r1 = c;
                    else if (r2 < 0) r2 = c;
                end
                prev = bus2.sck;
                if (bus2.done === 1'b1) begin dc = c; qd = bus2.q; end
                if (bus2.busy !== 1'b1) break;
                @(negedge clk);
                c++;
            end
            n_tests++;
            if (dc !== LAT2) begin n_fail++; $display("FAIL small_done_cycle%0d: got %0d expected %0d", i, dc, LAT2); end
            n_tests++;
            if (qd !== words[i]) begin n_fail++; $display("FAIL small_q%0d: got %h expected %h", i, qd, words[i]); end
            n_tests++;
            if (nr !== DW2) begin n_fail++; $display("FAIL small_rises%0d: got %0d expected %0d", i, nr, DW2); end
            n_tests++;
            if (r2 - r1 !== 2 * CD2) begin
                n_fail++;
                $display("FAIL small_sck_period%0d: got %0d expected %0d", i, r2 - r1, 2 * CD2);
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        loop_mode  = 1'b1;
        slave_miso = 1'b0;
        bus.start  = 1'b0;
        bus.d      = '0;
        bus2.start = 1'b0;
        bus2.d     = '0;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b0;
        @(negedge clk);
        test_loopback();
        test_slave();
        test_random();
        test_ignored_start();
        test_back_to_back();
        test_d_change();
        test_reset_midframe();
        test_reset_start();
        test_small();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter DATA_WIDTH, default 32: frame length in bits.
REQ-002 Parameter CLK_DIV, default 4: SCK half-period in clk cycles; legal range 2..255.
REQ-003 clk  input  1: single system clock; all logic on rising edge.
REQ-004 reset  input  1: synchronous, active-high reset.
REQ-005 start  input  1: one-cycle request to send d; accepted only when busy=0.
REQ-006 d  input  DATA_WIDTH: word to transmit, MSB first.
REQ-007 q  output  DATA_WIDTH: last complete word received on miso.
REQ-008 busy  output  1: high from the cycle after start is accepted until the frame ends.
REQ-009 done  output  1: one-cycle pulse; q is valid in that cycle.
REQ-010 sck  output  1: SPI clock, mode 0 (idle low).
REQ-011 cs_n  output  1: active-low chip select.
REQ-012 mosi  output  1: serial data out.
REQ-013 miso  input  1: serial data in; synchronised by 2 flops before sampling.

Function
REQ-014 The FSM SHALL have states IDLE, SETUP, SHIFT, HOLD, GAP; busy = (state != IDLE).
REQ-015 In IDLE: cs_n=1, sck=0, mosi=0; start=1 latches d into the TX shift register and moves to SETUP.
REQ-016 SETUP: cs_n=0, sck=0, mosi=d[DATA_WIDTH-1]; lasts CLK_DIV cycles, then SHIFT.
REQ-017 SHIFT: sck toggles every CLK_DIV cycles, starting with a rising edge; exactly DATA_WIDTH rising and DATA_WIDTH falling edges.
REQ-018 On each sck rising edge, the synchronised miso SHALL be shifted into the RX register LSB side.
REQ-019 On each sck falling edge except the last, mosi SHALL advance to the next lower bit.
REQ-020 After the final falling edge: HOLD, with cs_n=0, sck=0, mosi held, for CLK_DIV cycles.
REQ-021 GAP: cs_n=1, sck=0, mosi=0; lasts CLK_DIV cycles, then IDLE.
REQ-022 On entry to GAP: q <= RX register, and done=1 for exactly that one cycle.
REQ-023 Latency: done SHALL assert exactly (2*DATA_WIDTH+2)*CLK_DIV+1 cycles after the cycle in which start was sampled high in IDLE (265 cycles at defaults).
REQ-024 The next start SHALL be accepted at the earliest on the first IDLE cycle after GAP, so cs_n stays high for at least CLK_DIV cycles between frames.
REQ-025 start while busy=1, including the done cycle, SHALL be ignored and not queued.
REQ-026 d SHALL be sampled only at acceptance; later changes to d SHALL NOT affect the frame.
REQ-027 q SHALL hold its value between done pulses.
REQ-028 The bit counter and divider counter SHALL be sized for DATA_WIDTH and CLK_DIV with no wrap before frame end.

Reset
REQ-029 reset=1 SHALL give state=IDLE, cs_n=1, sck=0, mosi=0, busy=0, done=0, q=0, counters=0, sync flops=0, starting on the next clock edge.
REQ-030 Reset mid-frame SHALL abort immediately: no done, q unchanged from 0, and cs_n high on the next cycle.
REQ-031 If start and reset are both high in the same cycle, reset SHALL win.

Verification
REQ-032 Loopback (miso tied to mosi), d=0xA5C3_0F81, start pulse -> done at cycle 265, q=0xA5C3_0F81, exactly 32 sck rising edges, each with cs_n=0.
REQ-033 Slave model drives 0xDEAD_BEEF on its falling edges while master sends 0x1234_5678 -> the model captures 0x1234_5678 and q=0xDEAD_BEEF.
REQ-034 start pulsed again at cycles 10 and 265 (done cycle) of a frame -> both ignored; busy drops at cycle 269; a start at cycle 269 begins a new frame.
REQ-035 reset asserted at cycle 100 of a frame -> next cycle cs_n=1, sck=0, busy=0, no done pulse, q=0.
REQ-036 CLK_DIV=2, DATA_WIDTH=8, d=0x81, loopback -> done at cycle 37, q=0x81, sck period 4 cycles.
REQ-037 d changed on the cycle after start -> the transmitted word equals the value sampled at acceptance.
